// File: rtl/s3g_master.sv
// S3G packet initiator: frames D5/len/payload/CRC-8 commands towards a UART,
// then receives, checks and streams the response (or an unsolicited packet).
module s3g_master #(
  parameter int MAX_LEN = 32,
  parameter int TIMEOUT = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] cmd_len,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_len,
  output logic       rsp_done,
  output logic [1:0] rsp_status,
  output logic       rsp_unsol
);

  localparam logic [7:0] SYNC      = 8'hD5;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam int         TW        = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_CRC     = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_LEN     = 2'd3;

  typedef enum logic [3:0] {
    IDLE, TX_SYNC, TX_LEN, TX_PAY, TX_CRC, RX_SYNC, RX_LEN, RX_PAY, RX_CRC
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    crc_q, crc_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          in_flight_q, in_flight_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_wr_q, tx_wr_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_len_q, rsp_len_d;
  logic          rsp_done_q, rsp_done_d;
  logic [1:0]    rsp_status_q, rsp_status_d;
  logic          rsp_unsol_q, rsp_unsol_d;

  logic rx_state;
  logic timed_out;
  logic accept;

  // iButton CRC-8: reflected poly 0x8C, data shifted in LSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign cmd_ready  = (state_q == TX_PAY) && !in_flight_q && (cnt_q != len_q);
  assign busy       = (state_q != IDLE);
  assign tx_data    = tx_data_q;
  assign tx_wr      = tx_wr_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_len    = rsp_len_q;
  assign rsp_done   = rsp_done_q;
  assign rsp_status = rsp_status_q;
  assign rsp_unsol  = rsp_unsol_q;

  assign rx_state = (state_q == RX_SYNC) || (state_q == RX_LEN) ||
                    (state_q == RX_PAY)  || (state_q == RX_CRC);
  // Fires one cycle early so the registered rsp_done lands exactly TIMEOUT
  // cycles after the last tx_done/rx_done pulse.
  assign timed_out = rx_state && !rx_done && (timer_q == TW'(TIMEOUT - 2));
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    crc_d        = crc_q;
    timer_d      = rx_state ? timer_q + TW'(1) : timer_q;
    in_flight_d  = in_flight_q;
    tx_data_d    = tx_data_q;
    tx_wr_d      = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_valid_d  = 1'b0;
    rsp_len_d    = rsp_len_q;
    rsp_done_d   = 1'b0;
    rsp_status_d = rsp_status_q;
    rsp_unsol_d  = rsp_unsol_q;

    case (state_q)
      IDLE: begin
        // An arriving D5 takes priority over a simultaneous start.
        if (rx_done && rx_data == SYNC) begin
          state_d     = RX_LEN;
          crc_d       = 8'h00;
          timer_d     = '0;
          rsp_unsol_d = 1'b1;
        end else if (start) begin
          len_d       = cmd_len;
          cnt_d       = 8'h00;
          crc_d       = 8'h00;
          tx_wr_d     = 1'b1;
          tx_data_d   = SYNC;
          in_flight_d = 1'b1;
          state_d     = TX_SYNC;
        end
      end
      TX_SYNC: begin
        if (tx_done) begin
          tx_wr_d   = 1'b1;
          tx_data_d = len_q;
          state_d   = TX_LEN;
        end
      end
      TX_LEN: begin
        if (tx_done) begin
          if (len_q == 8'h00) begin
            tx_wr_d   = 1'b1;
            tx_data_d = crc_q;
            state_d   = TX_CRC;
          end else begin
            in_flight_d = 1'b0;
            state_d     = TX_PAY;
          end
        end
      end
      TX_PAY: begin
        if (accept) begin
          tx_wr_d     = 1'b1;
          tx_data_d   = cmd_data;
          crc_d       = crc8_byte(crc_q, cmd_data);
          cnt_d       = 8'(cnt_q + 8'd1);
          in_flight_d = 1'b1;
        end else if (tx_done && in_flight_q) begin
          if (cnt_q == len_q) begin
            tx_wr_d   = 1'b1;
            tx_data_d = crc_q;
            state_d   = TX_CRC;
          end else begin
            in_flight_d = 1'b0;
          end
        end
      end
      TX_CRC: begin
        if (tx_done) begin
          in_flight_d = 1'b0;
          timer_d     = '0;
          state_d     = RX_SYNC;
        end
      end
      RX_SYNC: begin
        if (rx_done) begin
          timer_d = '0;
          if (rx_data == SYNC) begin
            crc_d       = 8'h00;
            rsp_unsol_d = 1'b0;
            state_d     = RX_LEN;
          end
        end
      end
      RX_LEN: begin
        if (rx_done) begin
          timer_d   = '0;
          rsp_len_d = rx_data;
          if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
            rsp_done_d   = 1'b1;
            rsp_status_d = ST_LEN;
            state_d      = IDLE;
          end else begin
            cnt_d   = 8'h00;
            state_d = RX_PAY;
          end
        end
      end
      RX_PAY: begin
        // Bytes stream out before the CRC is known; rsp_status tells the consumer.
        if (rx_done) begin
          timer_d     = '0;
          rsp_data_d  = rx_data;
          rsp_valid_d = 1'b1;
          crc_d       = crc8_byte(crc_q, rx_data);
          cnt_d       = 8'(cnt_q + 8'd1);
          if (8'(cnt_q + 8'd1) == rsp_len_q) state_d = RX_CRC;
        end
      end
      RX_CRC: begin
        if (rx_done) begin
          timer_d      = '0;
          rsp_done_d   = 1'b1;
          rsp_status_d = (rx_data == crc_q) ? ST_OK : ST_CRC;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timed_out) begin
      rsp_done_d   = 1'b1;
      rsp_status_d = ST_TIMEOUT;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= 8'h00;
      cnt_q        <= 8'h00;
      crc_q        <= 8'h00;
      timer_q      <= '0;
      in_flight_q  <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_wr_q      <= 1'b0;
      rsp_data_q   <= 8'h00;
      rsp_valid_q  <= 1'b0;
      rsp_len_q    <= 8'h00;
      rsp_done_q   <= 1'b0;
      rsp_status_q <= 2'd0;
      rsp_unsol_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      crc_q        <= crc_d;
      timer_q      <= timer_d;
      in_flight_q  <= in_flight_d;
      tx_data_q    <= tx_data_d;
      tx_wr_q      <= tx_wr_d;
      rsp_data_q   <= rsp_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_len_q    <= rsp_len_d;
      rsp_done_q   <= rsp_done_d;
      rsp_status_q <= rsp_status_d;
      rsp_unsol_q  <= rsp_unsol_d;
    end
  end

endmodule

// File: tb/tb_s3g_master.sv
// Bench for s3g_master: a UART stand-in answers tx_wr with tx_done, a
// packet-level model predicts tx bytes and response events.
module tb_s3g_master;

  localparam int TIMEOUT = 200;
  localparam int MAX_LEN = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cmd_len = 8'h00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       cmd_ready, busy, tx_wr, rsp_valid, rsp_done, rsp_unsol;
  logic [7:0] tx_data, rsp_data, rsp_len;
  logic [1:0] rsp_status;

  s3g_master #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_len(cmd_len),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .busy(busy), .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done),
    .rx_data(rx_data), .rx_done(rx_done), .rsp_data(rsp_data),
    .rsp_valid(rsp_valid), .rsp_len(rsp_len), .rsp_done(rsp_done),
    .rsp_status(rsp_status), .rsp_unsol(rsp_unsol)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic unsol; } val_t;
  typedef struct { logic [1:0] status; logic unsol; logic [7:0] len; bit chk_len; } done_t;

  logic [7:0] exp_tx[$];
  val_t       exp_val[$];
  done_t      exp_done[$];

  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   last_tx_done_cyc = 0;
  int   last_rx_cyc = 0;
  int   done_cyc = 0;
  bit   uart_busy = 1'b0;
  int   tx_lat = 3;
  logic m_unsol = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] crc_of(input logic [7:0] b[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (b[i]) begin
      c = c ^ b[i];
      repeat (8) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  // Packet-level prediction of what a received byte stream must produce.
  function automatic void model_rx(input logic [7:0] s[$], input bit from_idle);
    int i;
    logic [7:0] len;
    logic [7:0] pay[$];
    val_t v;
    done_t d;
    i = 0;
    while (i < s.size() && s[i] != 8'hD5) i++;
    if (i >= s.size()) begin
      if (!from_idle) begin
        d = '{status: 2'd2, unsol: m_unsol, len: 8'h00, chk_len: 1'b0};
        exp_done.push_back(d);
      end
      return;
    end
    m_unsol = from_idle;
    i++;
    if (i >= s.size()) begin
      d = '{status: 2'd2, unsol: m_unsol, len: 8'h00, chk_len: 1'b0};
      exp_done.push_back(d);
      return;
    end
    len = s[i];
    i++;
    if (len == 0 || len > MAX_LEN) begin
      d = '{status: 2'd3, unsol: m_unsol, len: len, chk_len: 1'b1};
      exp_done.push_back(d);
      return;
    end
    for (int k = 0; k < len; k++) begin
      if (i >= s.size()) begin
        d = '{status: 2'd2, unsol: m_unsol, len: len, chk_len: 1'b1};
        exp_done.push_back(d);
        return;
      end
      v = '{data: s[i], unsol: m_unsol};
      exp_val.push_back(v);
      pay.push_back(s[i]);
      i++;
    end
    if (i >= s.size()) begin
      d = '{status: 2'd2, unsol: m_unsol, len: len, chk_len: 1'b1};
    end else begin
      d = '{status: (s[i] == crc_of(pay)) ? 2'd0 : 2'd1, unsol: m_unsol, len: len, chk_len: 1'b1};
    end
    exp_done.push_back(d);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // UART transmitter stand-in: one tx_done pulse tx_lat cycles after each tx_wr.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && tx_wr && !uart_busy) begin
      uart_busy = 1'b1;
      repeat (tx_lat) @(posedge clk);
      #1 tx_done = 1'b1;
      last_tx_done_cyc = cyc;
      @(posedge clk);
      #1 tx_done = 1'b0;
      uart_busy = 1'b0;
    end
  end

  // Per-cycle compare of DUT outputs against the model queues.
  initial forever begin
    logic [7:0] e;
    val_t v;
    done_t d;
    @(negedge clk);
    if (rst_n) begin
      if (tx_wr) begin
        check("tx_pacing", uart_busy, 0);
        if (exp_tx.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL tx_extra: got byte %02h, want no write", tx_data);
        end else begin
          e = exp_tx.pop_front();
          check("tx_byte", tx_data, e);
        end
      end
      if (uart_busy) check("cmd_ready_throttle", cmd_ready, 0);
      if (rsp_valid) begin
        if (exp_val.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL rsp_valid_extra: got byte %02h, want none", rsp_data);
        end else begin
          v = exp_val.pop_front();
          check("rsp_data", rsp_data, v.data);
          check("rsp_valid_unsol", rsp_unsol, v.unsol);
        end
      end
      if (rsp_done) begin
        done_cyc = cyc;
        if (exp_done.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL rsp_done_extra: got status %0d, want none", rsp_status);
        end else begin
          d = exp_done.pop_front();
          check("rsp_status", rsp_status, d.status);
          check("rsp_done_unsol", rsp_unsol, d.unsol);
          if (d.chk_len) check("rsp_len", rsp_len, d.len);
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] pay[$], input int feed = 255);
    int t;
    exp_tx.push_back(8'hD5);
    exp_tx.push_back(8'(pay.size()));
    foreach (pay[i]) exp_tx.push_back(pay[i]);
    exp_tx.push_back(crc_of(pay));
    start = 1'b1;
    cmd_len = 8'(pay.size());
    tick();
    start = 1'b0;
    foreach (pay[i]) begin
      if (i >= feed) break;
      cmd_data = pay[i];
      cmd_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 500) begin
        @(negedge clk);
        t++;
      end
      check("cmd_ready_wait", t < 500, 1);
      tick();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_tx_drained();
    int t;
    t = 0;
    while ((exp_tx.size() != 0 || uart_busy) && t < 2000) begin
      tick();
      t++;
    end
    check("tx_drain", t < 2000, 1);
    tick(2);
  endtask

  task automatic rx_stream(input logic [7:0] s[$], input bit from_idle, input int start_at = -1);
    int t;
    model_rx(s, from_idle);
    foreach (s[i]) begin
      rx_data = s[i];
      rx_done = 1'b1;
      if (i == start_at) start = 1'b1;
      last_rx_cyc = cyc;
      tick();
      rx_done = 1'b0;
      start = 1'b0;
      tick(2);
    end
    t = 0;
    while ((exp_val.size() != 0 || exp_done.size() != 0) && t < 2 * TIMEOUT) begin
      tick();
      t++;
    end
    check("rsp_wait", t < 2 * TIMEOUT, 1);
    tick(2);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] none[$];
    int t;

    q = '{8'h81};
    check("model_crc_81", crc_of(q), 8'hD2);
    q = '{8'h81, 8'hBA, 8'hCE};
    check("model_crc_81bace", crc_of(q), 8'hF9);
    q = '{8'h50, 8'h00, 8'h00, 8'h00, 8'h80};
    check("model_crc_unsol", crc_of(q), 8'h19);

    tick(3);
    check("rst_busy", busy, 0);
    check("rst_tx_wr", tx_wr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_done", rsp_done, 0);
    check("rst_rsp_fields", {rsp_data, rsp_len, rsp_status, rsp_unsol}, 0);
    rst_n = 1'b1;
    tick(2);

    // Version request
    tx_lat = 3;
    q = '{8'h00};
    send_cmd(q);
    wait_tx_drained();
    q = '{8'hD5, 8'h03, 8'h81, 8'hBA, 8'hCE, 8'hF9};
    rx_stream(q, 1'b0);
    check("ver_rsp_len", rsp_len, 8'h03);
    check("ver_status", rsp_status, 0);

    // LED write with a slower UART
    tx_lat = 5;
    q = '{8'h3C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_cmd(q);
    wait_tx_drained();
    q = '{8'hD5, 8'h01, 8'h81, 8'hD2};
    rx_stream(q, 1'b0);
    check("led_status", rsp_status, 0);

    // Garbage ahead of a response with a bad CRC
    tx_lat = 1;
    q = '{8'h01};
    send_cmd(q);
    wait_tx_drained();
    q = '{8'h00, 8'hFF, 8'hD5, 8'h01, 8'h81, 8'hD3};
    rx_stream(q, 1'b0);
    check("badcrc_status", rsp_status, 1);

    // No reply at all
    q = '{8'h02};
    send_cmd(q);
    wait_tx_drained();
    rx_stream(none, 1'b0);
    check("timeout_noreply_cycles", done_cyc - last_tx_done_cyc, TIMEOUT);
    check("timeout_noreply_status", rsp_status, 2);

    // Reply that stalls mid-payload
    q = '{8'h03};
    send_cmd(q);
    wait_tx_drained();
    q = '{8'hD5, 8'h02, 8'h81};
    rx_stream(q, 1'b0);
    check("timeout_partial_cycles", done_cyc - last_rx_cyc, TIMEOUT);

    // Unsolicited packet; start mid-packet must be dropped
    q = '{8'hD5, 8'h05, 8'h50, 8'h00, 8'h00, 8'h00, 8'h80, 8'h19};
    rx_stream(q, 1'b1, 3);
    check("unsol_flag", rsp_unsol, 1);
    check("unsol_status", rsp_status, 0);

    // Zero length, with start coinciding with the D5
    q = '{8'hD5, 8'h00};
    rx_stream(q, 1'b1, 0);
    check("len0_status", rsp_status, 3);

    // Length one beyond MAX_LEN
    q = '{8'hD5, 8'h21};
    rx_stream(q, 1'b1);
    check("len33_status", rsp_status, 3);
    check("len33_rsp_len", rsp_len, 8'h21);

    // Reset in the middle of the payload
    tx_lat = 2;
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_cmd(q, 2);
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_ready_wait", t < 500, 1);
    rst_n = 1'b0;
    tick();
    check("rst_mid_busy", busy, 0);
    check("rst_mid_tx_wr", tx_wr, 0);
    check("rst_mid_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1;
    exp_tx.delete();
    m_unsol = 1'b0;
    tick(3);
    q = '{8'h00};
    send_cmd(q);
    wait_tx_drained();
    q = '{8'hD5, 8'h01, 8'h81, 8'hD2};
    rx_stream(q, 1'b0);
    check("post_rst_status", rsp_status, 0);

    tick(5);
    check("leftover_expectations", exp_tx.size() + exp_val.size() + exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, want completion before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
